// File: rtl/nvram_save_bridge.sv
// Bridges the CPU NVRAM port to a host save-file stream: a save sweep packs nibble pairs
// into bytes on tx_*, a load sweep unpacks rx_* bytes back into the array.
module nvram_save_bridge #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [3:0]        cpu_wdata,
  output logic [3:0]        cpu_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_q,
  input  logic              save_req,
  input  logic              load_req,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done
);

  localparam int K_W = ADDR_W - 1;
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_LAST = {K_W{1'b1}};

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S_RD0  = 4'd1,
    S_RD1  = 4'd2,
    S_CAP  = 4'd3,
    S_TX   = 4'd4,
    L_WAIT = 4'd5,
    L_WR0  = 4'd6,
    L_WR1  = 4'd7,
    DONE   = 4'd8
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [K_W-1:0]  k_r;
  logic            k_adv_s;
  logic            last_byte_s;
  logic [3:0]      lo_nib_r;
  logic [7:0]      tx_data_r;
  logic [7:0]      rx_byte_r;
  logic            busy_r;
  logic            tx_valid_r;
  logic            rx_ready_r;
  logic            done_r;
  logic [ADDR_W-1:0] ram_addr_s;
  logic            ram_write_s;
  logic [3:0]      ram_wdata_s;

  assign last_byte_s = (k_r == K_LAST);

  // Next-state decode and byte-counter advance
  always_comb begin
    state_s = state_r;
    k_adv_s = 1'b0;
    case (state_r)
      IDLE: begin
        // save has priority when both requests arrive together
        if (save_req) begin
          state_s = S_RD0;
        end else if (load_req) begin
          state_s = L_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      S_RD0: state_s = S_RD1;
      S_RD1: state_s = S_CAP;
      S_CAP: state_s = S_TX;
      S_TX: begin
        if (tx_ready) begin
          k_adv_s = !last_byte_s;
          state_s = last_byte_s ? DONE : S_RD0;
        end else begin
          state_s = S_TX;
        end
      end
      L_WAIT: begin
        if (rx_valid) begin
          state_s = L_WR0;
        end else begin
          state_s = L_WAIT;
        end
      end
      L_WR0: state_s = L_WR1;
      L_WR1: begin
        k_adv_s = !last_byte_s;
        state_s = last_byte_s ? DONE : L_WAIT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and registered status outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      tx_valid_r <= 1'b0;
      rx_ready_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != IDLE);
      tx_valid_r <= (state_s == S_TX);
      rx_ready_r <= (state_s == L_WAIT);
      done_r     <= (state_s == DONE);
    end
  end

  // Byte counter and sweep datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      k_r       <= '0;
      lo_nib_r  <= 4'h0;
      tx_data_r <= 8'h00;
      rx_byte_r <= 8'h00;
    end else begin
      if (state_r == DONE) begin
        k_r <= '0;
      end else if (k_adv_s) begin
        k_r <= k_r + K_ONE;
      end
      // ram_q lags ram_addr by one cycle, so each nibble is captured a state later
      if (state_r == S_RD1) begin
        lo_nib_r <= ram_q;
      end
      if (state_r == S_CAP) begin
        tx_data_r <= {ram_q, lo_nib_r};
      end
      if ((state_r == L_WAIT) && rx_valid) begin
        rx_byte_r <= rx_data;
      end
    end
  end

  // NVRAM port: CPU pass-through in IDLE, sweep addressing otherwise
  always_comb begin
    ram_addr_s  = cpu_addr;
    ram_write_s = cpu_write;
    ram_wdata_s = cpu_wdata;
    if (reset) begin
      ram_addr_s  = '0;
      ram_write_s = 1'b0;
      ram_wdata_s = 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          ram_addr_s  = cpu_addr;
          ram_write_s = cpu_write;
          ram_wdata_s = cpu_wdata;
        end
        S_RD1: begin
          ram_addr_s  = {k_r, 1'b1};
          ram_write_s = 1'b0;
          ram_wdata_s = 4'h0;
        end
        L_WR0: begin
          ram_addr_s  = {k_r, 1'b0};
          ram_write_s = 1'b1;
          ram_wdata_s = rx_byte_r[3:0];
        end
        L_WR1: begin
          ram_addr_s  = {k_r, 1'b1};
          ram_write_s = 1'b1;
          ram_wdata_s = rx_byte_r[7:4];
        end
        S_RD0, S_CAP, S_TX, L_WAIT, DONE: begin
          ram_addr_s  = {k_r, 1'b0};
          ram_write_s = 1'b0;
          ram_wdata_s = 4'h0;
        end
        default: begin
          ram_addr_s  = '0;
          ram_write_s = 1'b0;
          ram_wdata_s = 4'h0;
        end
      endcase
    end
  end

  assign ram_addr  = ram_addr_s;
  assign ram_write = ram_write_s;
  assign ram_wdata = ram_wdata_s;
  assign cpu_q     = ram_q;
  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign rx_ready  = rx_ready_r;
  assign busy      = busy_r;
  assign cpu_hold  = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_nvram_save_bridge.sv
// Directed-plus-random bench for nvram_save_bridge: a behavioural NVRAM array, a nibble-level
// reference image of its expected contents, and byte packing computed from that image.
module tb_nvram_save_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_addr;
  logic       cpu_write;
  logic [3:0] cpu_wdata;
  logic [3:0] cpu_q;
  logic [7:0] ram_addr;
  logic       ram_write;
  logic [3:0] ram_wdata;
  logic [3:0] ram_q;
  logic       save_req;
  logic       load_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       cpu_hold;
  logic       done;

  logic [3:0] mem     [256];
  logic [3:0] exp_mem [256];
  logic [7:0] ld_bytes[$];
  logic [7:0] got[$];
  int checks = 0;
  int errors = 0;

  nvram_save_bridge #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_q(cpu_q),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_q(ram_q),
    .save_req(save_req), .load_req(load_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .cpu_hold(cpu_hold), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural 256x4 NVRAM with registered read
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] exp_byte(input int k);
    return {24'h0, exp_mem[2*k+1], exp_mem[2*k]};
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return {24'h0, got[i]};
    return 32'hDEAD;
  endfunction

  task automatic compare_mem(input string tag);
    for (int a = 0; a < 256; a++) check(tag, {28'h0, mem[a]}, {28'h0, exp_mem[a]});
  endtask

  // mode 0: tx_ready always high, 1: high one cycle in three, 2: random
  task automatic run_save(input int mode, input bit both_req);
    int c;
    int c_done;
    bit seen;
    bit pend;
    logic [7:0] pend_data;
    got.delete();
    seen = 1'b0; pend = 1'b0; c_done = 0; pend_data = 8'h00;
    save_req = 1'b1; load_req = both_req;
    step();
    save_req = 1'b0; load_req = 1'b0;
    for (c = 1; c <= 4000 && !seen; c++) begin
      check("save_busy", {31'h0, busy}, 32'd1);
      check("save_hold", {31'h0, cpu_hold}, 32'd1);
      check("save_rx_ready", {31'h0, rx_ready}, 32'd0);
      check("save_ram_write", {31'h0, ram_write}, 32'd0);
      if (done) begin
        seen = 1'b1;
        c_done = c;
      end else begin
        if (pend) begin
          check("tx_valid_held", {31'h0, tx_valid}, 32'd1);
          check("tx_data_stable", {24'h0, tx_data}, {24'h0, pend_data});
        end
        case (mode)
          0:       tx_ready = 1'b1;
          1:       tx_ready = (c % 3 == 0);
          default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        if (tx_valid && tx_ready) begin
          got.push_back(tx_data);
          pend = 1'b0;
        end else if (tx_valid) begin
          pend = 1'b1;
          pend_data = tx_data;
        end else begin
          pend = 1'b0;
        end
      end
      step();
    end
    tx_ready = 1'b0;
    check("save_done_seen", {31'h0, seen}, 32'd1);
    if (mode == 0) check("save_done_cycle", c_done, 32'd513);
    check("save_idle_busy", {31'h0, busy}, 32'd0);
    check("save_done_pulse", {31'h0, done}, 32'd0);
    check("save_count", got.size(), 32'd128);
    for (int k = 0; k < 128; k++) check("save_byte", got_at(k), exp_byte(k));
  endtask

  task automatic run_load(input bit valid_always, input int abort_after, input bit poke);
    int c;
    int c_done;
    int sent;
    bit seen;
    bit aborted;
    seen = 1'b0; aborted = 1'b0; sent = 0; c_done = 0;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    if (poke) begin
      cpu_addr = 8'h05; cpu_write = 1'b1; cpu_wdata = 4'hA;
    end
    for (c = 1; c <= 4000 && !seen && !aborted; c++) begin
      check("load_busy", {31'h0, busy}, 32'd1);
      check("load_tx_valid", {31'h0, tx_valid}, 32'd0);
      if (abort_after > 0 && sent == abort_after && rx_ready) begin
        aborted = 1'b1;
      end else begin
        if (done) begin
          seen = 1'b1;
          c_done = c;
          cpu_write = 1'b0;
          rx_valid = 1'b0;
        end else begin
          if (sent < ld_bytes.size()) begin
            rx_valid = valid_always ? 1'b1 : 1'($urandom_range(0, 1));
            rx_data = ld_bytes[sent];
          end else begin
            rx_valid = 1'b0;
          end
          if (rx_valid && rx_ready) sent++;
        end
        step();
      end
    end
    // reference: byte k lands as low nibble at 2k, high nibble at 2k+1
    for (int k = 0; k < sent; k++) begin
      exp_mem[2*k]   = ld_bytes[k][3:0];
      exp_mem[2*k+1] = ld_bytes[k][7:4];
    end
    if (abort_after > 0) begin
      check("abort_reached", {31'h0, aborted}, 32'd1);
      rx_valid = 1'b0;
      reset = 1'b1;
      step();
      check("abort_busy", {31'h0, busy}, 32'd0);
      check("abort_hold", {31'h0, cpu_hold}, 32'd0);
      check("abort_rx_ready", {31'h0, rx_ready}, 32'd0);
      check("abort_done", {31'h0, done}, 32'd0);
      check("abort_ram_write", {31'h0, ram_write}, 32'd0);
      cpu_write = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        step();
        check("abort_no_done", {31'h0, done}, 32'd0);
        check("abort_idle", {31'h0, busy}, 32'd0);
      end
    end else begin
      check("load_done_seen", {31'h0, seen}, 32'd1);
      check("load_count", sent, 32'd128);
      if (valid_always) check("load_done_cycle", c_done, 32'd385);
      check("load_idle_busy", {31'h0, busy}, 32'd0);
      check("load_done_pulse", {31'h0, done}, 32'd0);
    end
    cpu_write = 1'b0;
    compare_mem("load_mem");
  endtask

  initial begin
    reset = 1'b1; cpu_addr = 8'h33; cpu_write = 1'b1; cpu_wdata = 4'hF;
    save_req = 1'b0; load_req = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    step(); step(); step();
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_hold", {31'h0, cpu_hold}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'd0);
    check("rst_tx_data", {24'h0, tx_data}, 32'd0);
    check("rst_ram_addr", {24'h0, ram_addr}, 32'd0);
    check("rst_ram_write", {31'h0, ram_write}, 32'd0);
    check("rst_ram_wdata", {28'h0, ram_wdata}, 32'd0);
    cpu_write = 1'b0;
    reset = 1'b0;
    step();

    // preload through the IDLE pass-through with nib[a] = a[3:0]
    for (int a = 0; a < 256; a++) begin
      cpu_addr = 8'(a); cpu_write = 1'b1; cpu_wdata = 4'(a);
      exp_mem[a] = 4'(a);
      #1;
      if (a % 37 == 0) begin
        check("mirror_addr", {24'h0, ram_addr}, a);
        check("mirror_write", {31'h0, ram_write}, 32'd1);
        check("mirror_wdata", {28'h0, ram_wdata}, a % 16);
      end
      step();
    end
    cpu_write = 1'b0; cpu_addr = 8'h00;
    step();

    run_save(0, 1'b0);
    check("byte0", got_at(0), 32'h10);
    check("byte1", got_at(1), 32'h32);
    check("byte7", got_at(7), 32'hFE);
    check("byte8", got_at(8), 32'h10);

    ld_bytes.delete();
    for (int k = 0; k < 128; k++) ld_bytes.push_back(8'(k));
    run_load(1'b1, 0, 1'b0);
    run_save(2, 1'b0);

    ld_bytes.delete();
    for (int k = 0; k < 128; k++) ld_bytes.push_back(8'($urandom));
    run_load(1'b0, 0, 1'b1);
    check("poke_dropped", {28'h0, mem[5]}, {28'h0, ld_bytes[2][7:4]});
    run_save(1, 1'b0);
    run_save(2, 1'b1);

    cpu_addr = 8'h05; cpu_write = 1'b1; cpu_wdata = 4'hA;
    exp_mem[5] = 4'hA;
    step();
    cpu_write = 1'b0;
    step();
    check("idle_readback", {28'h0, cpu_q}, 32'hA);
    check("cpu_q_passthru", {28'h0, cpu_q}, {28'h0, ram_q});

    ld_bytes.delete();
    for (int k = 0; k < 128; k++) ld_bytes.push_back(8'($urandom));
    run_load(1'b0, 40, 1'b0);
    run_save(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
